// File: rtl/adc_sample_averager.sv
// Reads each XADC conversion over DRP and publishes the average of 2^LOG2_AVG samples.
// Optional macro SP_ADC_HYST_EN adds a hysteresis gate (HYST LSBs) on V_AVG updates.
module adc_sample_averager #(
  parameter int LOG2_AVG    = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int HYST        = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EOC,
  input  logic [4:0]  CHANNEL_IN,
  input  logic        DRDY,
  input  logic [15:0] DO,
  output logic        DEN,
  output logic [6:0]  DADDR,
  output logic [11:0] V_AVG,
  output logic        V_VALID,
  output logic        BUSY,
  output logic        TIMEOUT_ERR
);

  localparam int AW = 12 + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [4:0]    ch_q, ch_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          den_q, den_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [11:0]   v_avg_q, v_avg_d;
  logic          v_valid_q, v_valid_d;
  logic          busy_q, busy_d;
  logic          tmo_err_q, tmo_err_d;
  logic [AW-1:0] acc_sum;
  logic [11:0]   new_avg;
  logic          unused_ok;

`ifdef SP_ADC_HYST_EN
  logic               upd_seen_q, upd_seen_d;
  logic signed [12:0] diff;
  logic [12:0]        mag;
  assign unused_ok = &{1'b0, DO[3:0]};
`else
  assign unused_ok = &{1'b0, DO[3:0], 13'(HYST)};
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmo_d     = tmo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    den_d     = 1'b0;
    daddr_d   = 7'd0;
    v_avg_d   = v_avg_q;
    v_valid_d = 1'b0;
    tmo_err_d = tmo_err_q;
    acc_sum   = acc_q + AW'(DO[15:4]);
    new_avg   = acc_sum[AW-1:LOG2_AVG];
`ifdef SP_ADC_HYST_EN
    upd_seen_d = upd_seen_q;
    diff       = $signed({1'b0, new_avg}) - $signed({1'b0, v_avg_q});
    mag        = diff[12] ? 13'(-diff) : 13'(diff);
`endif

    case (state_q)
      S_IDLE: begin
        if (EOC) begin
          ch_d    = CHANNEL_IN;
          den_d   = 1'b1;
          daddr_d = {2'b00, CHANNEL_IN};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmo_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // DRDY has priority over the timeout terminal cycle
        if (DRDY) begin
          state_d = S_IDLE;
          if (cnt_q == CNT_LAST) begin
            acc_d = '0;
            cnt_d = '0;
`ifdef SP_ADC_HYST_EN
            if (!upd_seen_q || (mag >= 13'(HYST))) begin
              v_avg_d    = new_avg;
              v_valid_d  = 1'b1;
              upd_seen_d = 1'b1;
            end
`else
            v_avg_d   = new_avg;
            v_valid_d = 1'b1;
`endif
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      ch_q       <= 5'd0;
      tmo_q      <= 8'd0;
      acc_q      <= '0;
      cnt_q      <= '0;
      den_q      <= 1'b0;
      daddr_q    <= 7'd0;
      v_avg_q    <= 12'd0;
      v_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
`ifdef SP_ADC_HYST_EN
      upd_seen_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      den_q      <= den_d;
      daddr_q    <= daddr_d;
      v_avg_q    <= v_avg_d;
      v_valid_q  <= v_valid_d;
      busy_q     <= busy_d;
      tmo_err_q  <= tmo_err_d;
`ifdef SP_ADC_HYST_EN
      upd_seen_q <= upd_seen_d;
`endif
    end
  end

  assign DEN         = den_q;
  assign DADDR       = daddr_q;
  assign V_AVG       = v_avg_q;
  assign V_VALID     = v_valid_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager (LOG2_AVG=2, TIMEOUT_CYC=8, HYST=4).
// The hysteresis expectations follow SP_ADC_HYST_EN when it is defined.
module tb_adc_sample_averager;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EOC;
  logic [4:0]  CHANNEL_IN;
  logic        DRDY;
  logic [15:0] DO;
  logic        DEN;
  logic [6:0]  DADDR;
  logic [11:0] V_AVG;
  logic        V_VALID;
  logic        BUSY;
  logic        TIMEOUT_ERR;

  int vecs = 0;
  int errs = 0;
  int busy_cnt;

  adc_sample_averager #(.LOG2_AVG(2), .TIMEOUT_CYC(8), .HYST(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EOC(EOC), .CHANNEL_IN(CHANNEL_IN),
    .DRDY(DRDY), .DO(DO), .DEN(DEN), .DADDR(DADDR), .V_AVG(V_AVG),
    .V_VALID(V_VALID), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // EOC pulse; returns at the falling edge of the DEN cycle
  task automatic start_read(input logic [4:0] ch);
    @(negedge CLK);
    EOC = 1'b1;
    CHANNEL_IN = ch;
    @(negedge CLK);
    EOC = 1'b0;
    check("den", {15'd0, DEN}, 16'd1);
    check("daddr", {9'd0, DADDR}, {11'd0, ch});
  endtask

  // DRDY arrives 'dly' cycles after the DEN cycle
  task automatic finish_read(input int dly, input logic [15:0] data);
    repeat (dly) @(negedge CLK);
    DRDY = 1'b1;
    DO = data;
    @(negedge CLK);
    DRDY = 1'b0;
    DO = 16'd0;
  endtask

  task automatic read(input logic [4:0] ch, input int dly, input logic [15:0] data);
    start_read(ch);
    finish_read(dly, data);
  endtask

  task automatic block(input string tag, input logic [15:0] data,
                       input logic exp_valid, input logic [11:0] exp_avg);
    read(5'h07, 3, data);
    read(5'h07, 3, data);
    read(5'h07, 3, data);
    check({tag, "_early_valid"}, {15'd0, V_VALID}, 16'd0);
    read(5'h07, 3, data);
    check({tag, "_valid"}, {15'd0, V_VALID}, {15'd0, exp_valid});
    check({tag, "_avg"}, {4'd0, V_AVG}, {4'd0, exp_avg});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst_vavg", {4'd0, V_AVG}, 16'd0);
    check("rst_terr", {15'd0, TIMEOUT_ERR}, 16'd0);
    check("rst_busy", {15'd0, BUSY}, 16'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    EOC = 1'b0;
    CHANNEL_IN = 5'd0;
    DRDY = 1'b0;
    DO = 16'd0;
    repeat (2) @(negedge CLK);
    check("rst_den", {15'd0, DEN}, 16'd0);
    check("rst_daddr", {9'd0, DADDR}, 16'd0);
    check("rst_vavg", {4'd0, V_AVG}, 16'd0);
    check("rst_vvalid", {15'd0, V_VALID}, 16'd0);
    check("rst_busy", {15'd0, BUSY}, 16'd0);
    check("rst_terr", {15'd0, TIMEOUT_ERR}, 16'd0);
    RESET_N = 1'b1;

    // Basic block: (0x800+0x801+0x802+0x803)>>2 = 0x801
    read(5'h10, 3, 16'h8000);
    read(5'h10, 3, 16'h8010);
    read(5'h10, 3, 16'h8020);
    check("basic_early_valid", {15'd0, V_VALID}, 16'd0);
    read(5'h10, 3, 16'h8030);
    check("basic_valid", {15'd0, V_VALID}, 16'd1);
    check("basic_avg", {4'd0, V_AVG}, 16'h0801);
    @(negedge CLK);
    check("basic_valid_drop", {15'd0, V_VALID}, 16'd0);
    check("basic_hold", {4'd0, V_AVG}, 16'h0801);

    // DRDY on the last timeout cycle is accepted
    read(5'h01, 3, 16'hFFF0);
    read(5'h01, 3, 16'hFFF0);
    read(5'h01, 3, 16'hFFF0);
    read(5'h01, 8, 16'hFFF0);
    check("edge_valid", {15'd0, V_VALID}, 16'd1);
    check("edge_avg", {4'd0, V_AVG}, 16'h0FFF);
    check("edge_terr", {15'd0, TIMEOUT_ERR}, 16'd0);
    check("edge_busy", {15'd0, BUSY}, 16'd0);

    // EOC during WAIT and stray DRDY in IDLE are ignored
    read(5'h02, 3, 16'h4000);
    start_read(5'h02);
    @(negedge CLK);
    EOC = 1'b1;
    CHANNEL_IN = 5'h05;
    @(negedge CLK);
    EOC = 1'b0;
    check("ign_eoc_den", {15'd0, DEN}, 16'd0);
    finish_read(1, 16'h4000);
    @(negedge CLK);
    check("ign_no_den", {15'd0, DEN}, 16'd0);
    DRDY = 1'b1;
    DO = 16'hFFF0;
    @(negedge CLK);
    DRDY = 1'b0;
    DO = 16'd0;
    check("ign_stray_valid", {15'd0, V_VALID}, 16'd0);
    read(5'h02, 3, 16'h4000);
    check("ign_early_valid", {15'd0, V_VALID}, 16'd0);
    read(5'h02, 3, 16'h4000);
    check("ign_valid", {15'd0, V_VALID}, 16'd1);
    check("ign_avg", {4'd0, V_AVG}, 16'h0400);

    // Timeout: BUSY for 8 cycles after DEN, sample discarded, flag sticky
    start_read(5'h03);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BUSY) busy_cnt++;
    end
    check("tmo_busy_cycles", 16'(busy_cnt), 16'd8);
    check("tmo_err", {15'd0, TIMEOUT_ERR}, 16'd1);
    read(5'h03, 3, 16'h2000);
    read(5'h03, 3, 16'h2000);
    read(5'h03, 3, 16'h2000);
    check("tmo_early_valid", {15'd0, V_VALID}, 16'd0);
    read(5'h03, 3, 16'h2040);
    check("tmo_valid", {15'd0, V_VALID}, 16'd1);
    check("tmo_avg", {4'd0, V_AVG}, 16'h0201);
    check("tmo_err_sticky", {15'd0, TIMEOUT_ERR}, 16'd1);

    // Reset after two samples discards them
    read(5'h04, 3, 16'h5000);
    read(5'h04, 3, 16'h5000);
    do_reset();
    block("post_rst", 16'h1230, 1'b1, 12'h123);

    // First block after reset updates even with a tiny change from zero
    do_reset();
    block("first", 16'h0010, 1'b1, 12'h001);
    block("h100", 16'h1000, 1'b1, 12'h100);
`ifdef SP_ADC_HYST_EN
    block("h102", 16'h1020, 1'b0, 12'h100);
`else
    block("h102", 16'h1020, 1'b1, 12'h102);
`endif
    block("h105", 16'h1050, 1'b1, 12'h105);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Sits between the XADC DRP port and the voltage comparator / max-voltage register of the solar-panel optimizer.
- On each XADC end-of-conversion it performs a DRP read of the converted channel and extracts the 12-bit result.
- It accumulates 2^LOG2_AVG samples and presents one averaged, validated voltage word.
- This prevents single-sample noise from toggling the comparator's GT output and corrupting the stored maximum.

Parameters:
- LOG2_AVG, 2, log2 of samples per average (legal range 0..6; 0 = pass-through).
- TIMEOUT_CYC, 64, CLK cycles to wait for DRDY before aborting a read (legal range 2..255).
- HYST, 4, minimum LSB difference required to update V_AVG (used only with the optional feature).

Ports:
- CLK  in  1  system clock (PLL output domain, same as DRP dclk).
- RESET_N  in  1  asynchronous, active-low reset.
- EOC  in  1  XADC end-of-conversion, one-cycle pulse.
- CHANNEL_IN  in  5  XADC channel_out, valid when EOC=1.
- DRDY  in  1  XADC DRP data ready, one-cycle pulse.
- DO  in  16  XADC DRP read data; result is in DO[15:4].
- DEN  out  1  DRP enable, one-cycle pulse.
- DADDR  out  7  DRP address = {2'b00, latched channel}.
- V_AVG  out  12  averaged voltage, feeds comparator PV and FF_Array PV.
- V_VALID  out  1  one-cycle pulse when V_AVG is updated.
- BUSY  out  1  high while a DRP read is outstanding.
- TIMEOUT_ERR  out  1  sticky flag, set on a DRDY timeout.

Behaviour:
- Reset (async assert, sync release) forces all of the following:
  - Outputs: DEN=0, DADDR=0, V_AVG=0, V_VALID=0, BUSY=0, TIMEOUT_ERR=0.
  - Internal state: accumulator=0, sample count=0, state=IDLE.
- State machine has three states: IDLE, REQ, WAIT.
  - IDLE: on EOC=1, latch CHANNEL_IN, go to REQ.
  - REQ: for exactly one cycle drive DEN=1 and DADDR={2'b00,ch}; BUSY=1; clear the timeout counter; go to WAIT.
  - WAIT: BUSY=1.
    - If DRDY=1: add DO[15:4] to the accumulator, increment the count, go to IDLE.
    - Else if the timeout counter reaches TIMEOUT_CYC-1: set TIMEOUT_ERR, discard the sample (count unchanged), go to IDLE.
- Accumulator: width 12+LOG2_AVG bits, no overflow possible.
- When the count reaches 2^LOG2_AVG on a DRDY-accepted sample, in the next cycle:
  - V_AVG = accumulator of the completed block >> LOG2_AVG (truncate, no rounding).
  - V_VALID pulses for 1 cycle.
  - Accumulator and count restart at 0 (the just-accepted sample belongs to the completed block).
- Latency: from the DRDY of the last sample in a block to V_VALID is 1 CLK cycle. From EOC to DEN is 1 cycle.
- EOC arriving while not in IDLE is ignored (no queueing); the next EOC starts a new read.
- DRDY arriving outside WAIT is ignored.
- DRDY coincident with the timeout terminal cycle: the DRDY wins, the sample is accepted, and TIMEOUT_ERR is not set.
- TIMEOUT_ERR clears only on reset.
- Reset mid-read discards the partial accumulation. V_AVG returns to 0, so downstream FF_Array/comparator see PV=0 until the first new average.
- LOG2_AVG=0: every accepted sample produces V_VALID with V_AVG = DO[15:4].
- V_AVG holds its value between V_VALID pulses.

Optional Feature:
- Macro: SP_ADC_HYST_EN.
- Defined: at block completion, V_AVG is updated and V_VALID pulsed only if |new_avg − V_AVG| >= HYST, using 13-bit signed difference arithmetic.
  - Exception: the first block after reset always updates.
  - Otherwise V_AVG holds, V_VALID stays 0, and the accumulator still restarts.
- Undefined: every completed block updates V_AVG and pulses V_VALID. HYST is unused.

Test Plan:
- Reset/basic read:
  - Stimulus: LOG2_AVG=2; four EOCs with CHANNEL_IN=5'h10; DRDY 3 cycles after each DEN, DO=16'h8000, 16'h8010, 16'h8020, 16'h8030.
  - Required: each DEN has DADDR=7'h10; V_AVG=12'h801 one cycle after the 4th DRDY; V_VALID high for exactly one cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; EOC, then no DRDY.
  - Required: BUSY high for 8 cycles after DEN; TIMEOUT_ERR=1; count unchanged (a further 4 good samples are needed for V_VALID); TIMEOUT_ERR stays set.
- Ignored events:
  - Stimulus: EOC during WAIT; stray DRDY while IDLE.
  - Required: no extra DEN; accumulator unchanged; V_VALID timing unaffected.
- DRDY on the timeout boundary:
  - Stimulus: DRDY exactly on cycle TIMEOUT_CYC-1, DO=16'hFFF0.
  - Required: sample 12'hFFF accepted; TIMEOUT_ERR=0.
- Reset mid-block:
  - Stimulus: assert RESET_N=0 after 2 of 4 samples, then release and feed 4 samples of 16'h1230.
  - Required: V_AVG=0 during reset; then V_AVG=12'h123 with one V_VALID pulse.
- Hysteresis, with SP_ADC_HYST_EN and HYST=4:
  - Stimulus: first block averages to 12'h100, next to 12'h102, next to 12'h105.
  - Required: updates to 12'h100; then no V_VALID and V_AVG holds 12'h100; then update to 12'h105.
